// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared constants and types for the memory-mapped I/O
//               controller: register offsets inside the 256-byte window,
//               STATUS bit positions and the RX prefetch FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

  // Byte offsets inside the I/O window (addr[7:0], word aligned)
  localparam logic [7:0] OFF_UART_DATA = 8'h00;
  localparam logic [7:0] OFF_STATUS    = 8'h04;
  localparam logic [7:0] OFF_SEG       = 8'h08;
  localparam logic [7:0] OFF_LED       = 8'h0C;
  localparam logic [7:0] OFF_CYCLE     = 8'h10;

  // STATUS register layout
  localparam int STATUS_RX_VALID     = 0;
  localparam int STATUS_TX_READY     = 1;
  localparam int STATUS_RX_COUNT_LSB = 8;

  // RX prefetch FSM
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } pf_state_e;

endpackage
`default_nettype wire

// File: rtl/mmio_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count. Push and pop in the
//               same cycle are both honoured, including when full (the pop
//               frees the slot being written).
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               push_i, wdata_i  - write request and data
//               pop_i, rdata_o   - read request, head-of-queue data
//               full_o, empty_o  - occupancy flags
//               count_o          - number of stored entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  // DEPTH is a power of two and count never exceeds it, so the MSB alone flags full
  assign full_o  = count_q[AW];
  assign count_o = count_q;
  assign rdata_o = mem_q[head_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + AW'(1);
    if (do_pop)  head_d = head_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers/count define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mmio_ctrl
// Description : Memory-mapped I/O controller on the core data port. Decodes a
//               256-byte window at IO_BASE into UART data/status, hex-display,
//               LED and cycle-counter registers. Prefetches RX bytes from an
//               external FIFO into a local FIFO, stalls the core on blocking
//               empty reads and on TX back-pressure.
// Ports       : clk, rst_n                       - clock, async active-low reset
//               cpu_addr/wdata/we/re             - core access (held while stalled)
//               cpu_rdata                        - registered read data
//               cpu_stall                        - combinational stall
//               uart_in/uart_empty/uart_rdreq    - external RX FIFO
//               uart_out/uart_wrreq/uart_full    - external TX FIFO
//               seg_io, show                     - hex digits, LEDs
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] IO_BASE     = 32'hFFFF_FF00,
  parameter int                RX_DEPTH    = 8,
  parameter int                SEG_DIGITS  = 6,
  parameter int                LED_W       = 10,
  parameter int                BLOCKING_RX = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    cpu_we,
  input  logic                    cpu_re,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_stall,
  input  logic [7:0]              uart_in,
  input  logic                    uart_empty,
  output logic                    uart_rdreq,
  output logic [7:0]              uart_out,
  output logic                    uart_wrreq,
  input  logic                    uart_full,
  output logic [4*SEG_DIGITS-1:0] seg_io,
  output logic [LED_W-1:0]        show
);

  localparam int SEG_W = 4 * SEG_DIGITS;
  localparam int CNT_W = $clog2(RX_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  logic       in_win;
  logic [7:0] off;
  logic       sel_data, sel_status, sel_seg, sel_led, sel_cycle;

  assign in_win     = (cpu_addr[ADDR_W-1:8] == IO_BASE[ADDR_W-1:8]);
  assign off        = {cpu_addr[7:2], 2'b00};
  assign sel_data   = in_win && (off == OFF_UART_DATA);
  assign sel_status = in_win && (off == OFF_STATUS);
  assign sel_seg    = in_win && (off == OFF_SEG);
  assign sel_led    = in_win && (off == OFF_LED);
  assign sel_cycle  = in_win && (off == OFF_CYCLE);

  // ---------------------------------------------------------------- state
  pf_state_e            state_q, state_d;
  logic                 run_q;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic [LED_W-1:0]     led_q, led_d;
  logic [31:0]          cycle_q, cycle_d;
  logic [7:0]           uart_out_q, uart_out_d;
  logic                 wrreq_q, wrreq_d;

  // ---------------------------------------------------------------- RX FIFO
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_rdata;

  sync_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (uart_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------- access control
  logic rd_only, rx_avail, rx_stall, tx_stall, rd_acc, wr_acc;

  // A simultaneous write wins; the read half of the access is dropped
  assign rd_only   = cpu_re && !cpu_we;
  // The byte captured during FILL counts as available so an empty-FIFO read
  // can complete in the capture cycle instead of waiting one more
  assign rx_avail  = !fifo_empty || (state_q == FILL);
  assign rx_stall  = (BLOCKING_RX != 0) && rd_only && sel_data && !rx_avail;
  assign tx_stall  = cpu_we && sel_data && uart_full;
  assign cpu_stall = rx_stall || tx_stall;
  assign rd_acc    = rd_only && !cpu_stall;
  assign wr_acc    = cpu_we && !cpu_stall;

  assign fifo_pop  = rd_acc && sel_data && !fifo_empty;
  // When the FIFO is empty and the core takes the FILL byte directly,
  // it bypasses storage entirely
  assign fifo_push = (state_q == FILL) && !(rd_acc && sel_data && fifo_empty);

  // ---------------------------------------------------------------- prefetch FSM
  always_comb begin
    state_d    = state_q;
    uart_rdreq = 1'b0;
    case (state_q)
      IDLE: begin
        // run_q keeps the external pop quiet until the first edge after reset
        if (run_q && !uart_empty && !fifo_full) begin
          uart_rdreq = 1'b1;
          state_d    = FILL;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- read mux
  logic [DATA_W-1:0] status;

  always_comb begin
    status                                   = '0;
    status[STATUS_RX_VALID]                  = !fifo_empty;
    status[STATUS_TX_READY]                  = !uart_full;
    status[STATUS_RX_COUNT_LSB +: CNT_W]     = fifo_count;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) begin
      rdata_d = '0;
      if (sel_data) begin
        if (!fifo_empty)           rdata_d = DATA_W'(fifo_rdata);
        else if (state_q == FILL)  rdata_d = DATA_W'(uart_in);
        else                       rdata_d = '1;  // non-blocking empty read
      end else if (sel_status) begin
        rdata_d = status;
      end else if (sel_seg) begin
        rdata_d = DATA_W'(seg_q);
      end else if (sel_led) begin
        rdata_d = DATA_W'(led_q);
      end else if (sel_cycle) begin
        rdata_d = DATA_W'(cycle_q);
      end
    end
  end

  // ---------------------------------------------------------------- write side
  always_comb begin
    seg_d      = seg_q;
    led_d      = led_q;
    uart_out_d = uart_out_q;
    wrreq_d    = 1'b0;
    cycle_d    = cycle_q + 32'd1;
    if (wr_acc) begin
      if (sel_seg)   seg_d   = cpu_wdata[SEG_W-1:0];
      if (sel_led)   led_d   = cpu_wdata[LED_W-1:0];
      if (sel_cycle) cycle_d = '0;
      if (sel_data) begin
        uart_out_d = cpu_wdata[7:0];
        wrreq_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      rdata_q    <= '0;
      seg_q      <= '0;
      led_q      <= '0;
      cycle_q    <= '0;
      uart_out_q <= '0;
      wrreq_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      rdata_q    <= rdata_d;
      seg_q      <= seg_d;
      led_q      <= led_d;
      cycle_q    <= cycle_d;
      uart_out_q <= uart_out_d;
      wrreq_q    <= wrreq_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign seg_io     = seg_q;
  assign show       = led_q;
  assign uart_out   = uart_out_q;
  assign uart_wrreq = wrreq_q;

  // Byte-lane bits and the upper write-data bits have no consumer
  logic unused_bits;
  assign unused_bits = ^{cpu_addr[1:0], cpu_wdata};

endmodule
`default_nettype wire
